// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the arbitrated N-input multiplexer.
package mux_arb_pkg;

    localparam int MUX_ARB_MAX_N = 16;

    // Encodes a one-hot (or all-zero) vector into the index of its set bit.
    function automatic logic [3:0] onehot_to_idx(input logic [MUX_ARB_MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MUX_ARB_MAX_N; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational picker: first requesting channel at or after ptr, wrapping at N.
module rr_picker
    import mux_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic                     found;
    logic [MUX_ARB_MAX_N-1:0] oh_ext;

    // Two passes: indices ptr..N-1 first, then 0..ptr-1, so the wrap is at N.
    always_comb begin
        gnt_onehot = '0;
        found      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        oh_ext         = '0;
        oh_ext[N-1:0]  = gnt_onehot;
        gnt_idx        = SELW'(onehot_to_idx(oh_ext));
    end

    assign any = |req;

endmodule

// File: rtl/mux_arb_n.sv
// N-input arbitrated mux with valid/ready handshakes and one registered output stage.
// Build option: define MUX_ARB_RR_EN for round-robin; otherwise lowest index wins.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 32,
    localparam int SELW = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N*W-1:0]  IN_DATA,
    input  logic [N-1:0]    IN_VALID,
    output logic [N-1:0]    IN_READY,
    input  logic [N-1:0]    EN_MASK,
    output logic [W-1:0]    OUT_DATA,
    output logic [SELW-1:0] OUT_SEL,
    output logic            OUT_VALID,
    input  logic            OUT_READY
);

    if (N < 2 || N > MUX_ARB_MAX_N || W < 1) begin : g_bad_param
        $error("mux_arb_n: N must be 2..%0d and W at least 1", MUX_ARB_MAX_N);
    end

    logic [N-1:0]    req;
    logic [N-1:0]    gnt_onehot;
    logic [SELW-1:0] gnt_idx;
    logic [SELW-1:0] ptr;
    logic            any;
    logic            load;
    logic            take;
    logic [W-1:0]    sel_data;

    logic            vld_p0;
    logic [W-1:0]    data_p0;
    logic [SELW-1:0] sel_p0;

    assign req      = IN_VALID & EN_MASK;
    assign load     = !vld_p0 || OUT_READY;
    assign take     = load && any && !RST;
    assign IN_READY = take ? gnt_onehot : '0;

    rr_picker #(.N(N)) u_picker (
        .req        (req),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_onehot[i]) sel_data = sel_data | IN_DATA[i*W +: W];
        end
    end

`ifdef MUX_ARB_RR_EN
    logic [SELW-1:0] ptr_p0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_p0 <= '0;
        end else if (take) begin
            ptr_p0 <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
        end
    end

    assign ptr = ptr_p0;
`else
    assign ptr = '0;
`endif

    // Output stage: loads when empty or draining; an empty request set drains the slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            sel_p0  <= '0;
        end else if (load) begin
            vld_p0 <= any;
            if (any) begin
                data_p0 <= sel_data;
                sel_p0  <= gnt_idx;
            end
        end
    end

    assign OUT_VALID = vld_p0;
    assign OUT_DATA  = data_p0;
    assign OUT_SEL   = sel_p0;

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n (N=4 main instance, N=3 wrap instance); honours MUX_ARB_RR_EN.
module tb_mux_arb_n;

    localparam int N = 4;
    localparam int W = 32;
`ifdef MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready, en_mask;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid, out_ready;

    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3, in_ready3, en_mask3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_sel3;
    logic           out_valid3, out_ready3;

    mux_arb_n #(.N(N), .W(W)) dut (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .EN_MASK(en_mask), .OUT_DATA(out_data), .OUT_SEL(out_sel), .OUT_VALID(out_valid),
        .OUT_READY(out_ready)
    );

    mux_arb_n #(.N(3), .W(W)) dut3 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
        .EN_MASK(en_mask3), .OUT_DATA(out_data3), .OUT_SEL(out_sel3), .OUT_VALID(out_valid3),
        .OUT_READY(out_ready3)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   s;
    } beat_t;

    beat_t q[$];
    beat_t exp_beat;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every beat the consumer accepts must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got data %0h sel %0d, expected no beat", out_data, out_sel);
            end else begin
                exp_beat = q.pop_front();
                check("out_data", 64'(out_data), 64'(exp_beat.d));
                check("out_sel", 64'(out_sel), 64'(exp_beat.s));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a grant to channel ch this cycle, queue its beat, advance one clock.
    task automatic grant(input int ch, input string name);
        #1;
        check(name, 64'(in_ready), 64'(1) << ch);
        q.push_back('{d: W'(32'hA0 + ch), s: 2'(ch)});
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        en_mask   = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(32'hA0 + i);
        in_valid3  = 3'b000;
        en_mask3   = 3'b111;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) in_data3[i*W +: W] = W'(32'hC0 + i);

        // Reset with all channels valid
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        step();
        step();
        check("rst_in_ready2", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_sel", 64'(out_sel), 64'(0));
        rst = 1'b0;

        // Fairness: eight back-to-back beats with every channel valid
        for (int k = 0; k < 8; k++) grant(RR ? (k % 4) : 0, "fair_in_ready");

        // Backpressure: load A2 then stall three cycles
        in_valid = 4'b0100;
        grant(2, "bp_load_in_ready");
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_data", 64'(out_data), 64'(32'hA2));
            check("bp_out_sel", 64'(out_sel), 64'(2));
            step();
        end
        out_ready = 1'b1;
        grant(RR ? 3 : 0, "bp_release_in_ready");

        // Wrap: ch2, then only ch1, then all valid shows the pointer position
        in_valid = 4'b0100;
        grant(2, "wrap_ch2");
        in_valid = 4'b0010;
        grant(1, "wrap_ch1");
        in_valid = 4'hF;
        grant(RR ? 2 : 0, "wrap_after");

        // Mask: only channels 1 and 3 eligible
        en_mask = 4'b1010;
        grant(RR ? 3 : 1, "mask_a");
        grant(1, "mask_b");
        grant(RR ? 3 : 1, "mask_c");
        grant(1, "mask_d");
        en_mask = 4'b0000;
        #1;
        check("mask_none_in_ready", 64'(in_ready), 64'(0));
        step();
        check("mask_drain_out_valid", 64'(out_valid), 64'(0));

        // Beat stalled while its channel gets masked still drains
        en_mask  = 4'hF;
        in_valid = 4'b0001;
        grant(0, "stallmask_load");
        out_ready = 1'b0;
        en_mask   = 4'b0000;
        in_valid  = 4'hF;
        #1;
        check("stallmask_held", 64'(out_valid), 64'(1));
        step();
        out_ready = 1'b1;
        #1;
        check("stallmask_in_ready", 64'(in_ready), 64'(0));
        step();
        check("stallmask_drained", 64'(out_valid), 64'(0));

        // Reset during a stall discards the held beat and clears the pointer
        en_mask  = 4'hF;
        in_valid = 4'b0100;
        #1;
        check("midrst_load", 64'(in_ready), 64'(4'b0100));
        step();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        rst       = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        step();
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        check("midrst_out_sel", 64'(out_sel), 64'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        grant(0, "midrst_first_grant");
        in_valid = 4'h0;
        step();
        step();
        check("queue_empty", 64'(q.size()), 64'(0));

        // N=3 instance: pointer wraps from 2 back to 0
        in_valid3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("n3_in_ready", 64'(in_ready3), 64'(1) << (RR ? (k % 3) : 0));
            step();
            check("n3_out_sel", 64'(out_sel3), 64'(RR ? (k % 3) : 0));
            check("n3_out_data", 64'(out_data3), 64'(32'hC0 + (RR ? (k % 3) : 0)));
        end
        in_valid3 = 3'b000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
